// File: rtl/game_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : game_sequencer_if                                     |
// | Brief    : Button / ALU / RNG / display signal bundle for the    |
// |            BCD math game round controller.                       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface game_sequencer_if;
  logic       Start_Btn;
  logic       Submit_Btn;
  logic       Score_Req;
  logic       Game_Start;
  logic       Load_Input;
  logic       Timeout;
  logic       RNG_Next;
  logic [6:0] Time_Left;
  logic       Game_Active;
  logic       Game_Over;

  // The sequencer itself
  modport master (
    input  Start_Btn, Submit_Btn, Score_Req,
    output Game_Start, Load_Input, Timeout, RNG_Next,
           Time_Left, Game_Active, Game_Over
  );

  // Board / ALU / RNG side
  modport slave (
    output Start_Btn, Submit_Btn, Score_Req,
    input  Game_Start, Load_Input, Timeout, RNG_Next,
           Time_Left, Game_Active, Game_Over
  );
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : game_sequencer                                        |
// | Brief    : Round controller for the BCD math game: button edge   |
// |            strobes, round countdown, RNG requests and the        |
// |            end-of-game score handshake.                          |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module game_sequencer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int GAME_SECONDS  = 60,
  parameter int SETTLE_CYC    = 2
) (
  input logic              clk,
  input logic              reset,
  game_sequencer_if.master bus
);

  localparam int c_TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int c_SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [c_SET_W-1:0]  c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);
  localparam logic [6:0]          c_SECONDS  = 7'(GAME_SECONDS);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_ROUND      = 3'd2,
    S_SETTLE     = 3'd3,
    S_WAIT_SCORE = 3'd4,
    S_DONE       = 3'd5,
    S_ACK        = 3'd6
  } state_t;

  state_t              r_state;
  logic [c_TICK_W-1:0] r_tick;
  logic [c_SET_W-1:0]  r_settle_cnt;
  logic [6:0]          r_time_left;
  logic                r_game_start;
  logic                r_load_input;
  logic                r_rng_next;
  logic                r_timeout;
  logic                r_game_active;
  logic                r_game_over;

  logic r_start_s1, r_start_s2, r_start_prev;
  logic r_submit_s1, r_submit_s2, r_submit_prev;

  logic w_start_edge;
  logic w_submit_edge;
  logic w_wrap;

  // Two-flop synchronisers plus previous-value flops for rising-edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_start_s1    <= 1'b0;
      r_start_s2    <= 1'b0;
      r_start_prev  <= 1'b0;
      r_submit_s1   <= 1'b0;
      r_submit_s2   <= 1'b0;
      r_submit_prev <= 1'b0;
    end else begin
      r_start_s1    <= bus.Start_Btn;
      r_start_s2    <= r_start_s1;
      r_start_prev  <= r_start_s2;
      r_submit_s1   <= bus.Submit_Btn;
      r_submit_s2   <= r_submit_s1;
      r_submit_prev <= r_submit_s2;
    end
  end

  assign w_start_edge  = r_start_s2 & ~r_start_prev;
  assign w_submit_edge = r_submit_s2 & ~r_submit_prev;
  assign w_wrap        = (r_tick == c_TICK_MAX);

  // Round state machine with registered strobes, timer and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_tick        <= '0;
      r_settle_cnt  <= '0;
      r_time_left   <= 7'd0;
      r_game_start  <= 1'b0;
      r_load_input  <= 1'b0;
      r_rng_next    <= 1'b0;
      r_timeout     <= 1'b1;
      r_game_active <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a branch below re-asserts them
      r_game_start <= 1'b0;
      r_load_input <= 1'b0;
      r_rng_next   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_timeout <= 1'b1;
          if (w_start_edge) begin
            // Load the round length on entry so it is visible with Game_Start
            r_state       <= S_ARM;
            r_game_start  <= 1'b1;
            r_rng_next    <= 1'b1;
            r_time_left   <= c_SECONDS;
            r_tick        <= '0;
            r_game_active <= 1'b1;
          end
        end

        S_ARM: begin
          r_time_left <= c_SECONDS;
          r_tick      <= '0;
          r_state     <= S_ROUND;
        end

        S_ROUND, S_SETTLE: begin
          r_tick <= w_wrap ? '0 : r_tick + c_TICK_W'(1);
          if (w_wrap && (r_time_left == 7'd1)) begin
            // Expiry beats any pending Submit edge or RNG request
            r_time_left   <= 7'd0;
            r_timeout     <= 1'b0;
            r_state       <= S_WAIT_SCORE;
            r_game_active <= 1'b0;
            r_game_over   <= 1'b1;
          end else begin
            if (w_wrap) begin
              r_time_left <= r_time_left - 7'd1;
            end
            if (r_state == S_ROUND) begin
              if (w_submit_edge) begin
                r_load_input <= 1'b1;
                r_settle_cnt <= '0;
                r_state      <= S_SETTLE;
              end
            end else if (r_settle_cnt == c_SET_LAST) begin
              r_rng_next <= 1'b1;
              r_state    <= S_ROUND;
            end else begin
              r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
            end
          end
        end

        S_WAIT_SCORE: begin
          r_timeout <= 1'b0;
          if (bus.Score_Req) begin
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_time_left <= 7'd0;
          if (w_start_edge) begin
            r_load_input <= 1'b1;
            r_state      <= S_ACK;
          end
        end

        S_ACK: begin
          r_timeout   <= 1'b1;
          r_game_over <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state       <= S_IDLE;
          r_tick        <= '0;
          r_settle_cnt  <= '0;
          r_time_left   <= 7'd0;
          r_timeout     <= 1'b1;
          r_game_active <= 1'b0;
          r_game_over   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Game_Start  = r_game_start;
  assign bus.Load_Input  = r_load_input;
  assign bus.RNG_Next    = r_rng_next;
  assign bus.Timeout     = r_timeout;
  assign bus.Time_Left   = r_time_left;
  assign bus.Game_Active = r_game_active;
  assign bus.Game_Over   = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_game_sequencer                                     |
// | Brief    : Self-checking bench for game_sequencer using a        |
// |            deadline-based reference model of a game round.       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_game_sequencer;

  localparam int TPS = 10;
  localparam int GS  = 3;
  localparam int SC  = 2;

  localparam int P_IDLE = 0;
  localparam int P_PLAY = 1;
  localparam int P_WAIT = 2;
  localparam int P_DONE = 3;
  localparam int P_ACK  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  game_sequencer_if bus ();

  game_sequencer #(
    .TICKS_PER_SEC (TPS),
    .GAME_SECONDS  (GS),
    .SETTLE_CYC    (SC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  // Reference model: a round is an arm edge plus a fixed deadline
  int m_phase = P_IDLE;
  int m_arm   = 0;
  int m_end   = 0;
  int m_load  = -1000;
  bit st_p1, st_p2, st_p3;
  bit su_p1, su_p2, su_p3;
  bit e_gs, e_load, e_rng;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, k);
    end
  endtask

  function automatic int exp_time_left();
    int el;
    if (m_phase != P_PLAY) return 0;
    el = k - m_arm - 1;
    if (el < 0) el = 0;
    return GS - el / TPS;
  endfunction

  // One clock edge: advance the model with the inputs present at the edge, then compare
  task automatic step();
    bit st_raw, su_raw, sr, rs, se, ue;
    st_raw = bus.Start_Btn;
    su_raw = bus.Submit_Btn;
    sr     = bus.Score_Req;
    rs     = reset;
    @(posedge clk);
    k++;
    e_gs = 0; e_load = 0; e_rng = 0;
    if (!rs) begin
      m_phase = P_IDLE;
      st_p1 = 0; st_p2 = 0; st_p3 = 0;
      su_p1 = 0; su_p2 = 0; su_p3 = 0;
    end else begin
      // A raw rise sampled at edge j is acted on at edge j+2
      se = st_p2 & ~st_p3;
      ue = su_p2 & ~su_p3;
      st_p3 = st_p2; st_p2 = st_p1; st_p1 = st_raw;
      su_p3 = su_p2; su_p2 = su_p1; su_p1 = su_raw;
      case (m_phase)
        P_IDLE: if (se) begin
          m_arm = k;
          m_end = k + 1 + GS * TPS;
          m_load = -1000;
          m_phase = P_PLAY;
          e_gs = 1; e_rng = 1;
        end
        P_PLAY: begin
          if (k == m_end) begin
            m_phase = P_WAIT;
          end else begin
            if (k == m_load + SC) e_rng = 1;
            if (ue && k >= m_arm + 2 && k >= m_load + SC + 1) begin
              m_load = k;
              e_load = 1;
            end
          end
        end
        P_WAIT: if (sr) m_phase = P_DONE;
        P_DONE: if (se) begin
          m_phase = P_ACK;
          e_load = 1;
        end
        default: m_phase = P_IDLE;
      endcase
    end
    #1;
    check("game_start",  bus.Game_Start,  int'(e_gs));
    check("load_input",  bus.Load_Input,  int'(e_load));
    check("rng_next",    bus.RNG_Next,    int'(e_rng));
    check("time_left",   bus.Time_Left,   exp_time_left());
    check("timeout",     bus.Timeout,     int'(m_phase == P_IDLE || m_phase == P_PLAY));
    check("game_active", bus.Game_Active, int'(m_phase == P_PLAY));
    check("game_over",   bus.Game_Over,   int'(m_phase == P_WAIT || m_phase == P_DONE || m_phase == P_ACK));
  endtask

  task automatic press_start();
    bus.Start_Btn = 1'b1;
    repeat (4) step();
    bus.Start_Btn = 1'b0;
    step();
  endtask

  task automatic wait_phase(input string tag, input int ph, input int budget);
    int n;
    n = 0;
    while (m_phase != ph && n < budget) begin
      step();
      n++;
    end
    check({"bound_", tag}, (n < budget), 1);
  endtask

  task automatic score_pulse();
    bus.Score_Req = 1'b1;
    step();
    bus.Score_Req = 1'b0;
    step();
  endtask

  initial begin
    bus.Start_Btn  = 1'b0;
    bus.Submit_Btn = 1'b0;
    bus.Score_Req  = 1'b0;

    // Reset state
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    // Start a round and let it expire with no answers
    press_start();
    wait_phase("expiry", P_WAIT, 100);
    repeat (5) step();
    score_pulse();
    press_start();
    wait_phase("ack", P_IDLE, 20);
    repeat (3) step();

    // New round: a double-tap whose second edge lands in SETTLE, then a long hold
    press_start();
    repeat (3) step();
    bus.Submit_Btn = 1'b1; step();
    bus.Submit_Btn = 1'b0; step();
    bus.Submit_Btn = 1'b1;
    repeat (20) step();
    bus.Submit_Btn = 1'b0;
    wait_phase("round2", P_WAIT, 100);
    score_pulse();
    press_start();
    wait_phase("ack2", P_IDLE, 20);

    // Submit edge coinciding with the expiry edge
    press_start();
    while (m_phase == P_PLAY && k < m_end - 3) step();
    bus.Submit_Btn = 1'b1;
    wait_phase("collide", P_WAIT, 20);
    repeat (3) step();
    bus.Submit_Btn = 1'b0;
    score_pulse();
    press_start();
    wait_phase("ack3", P_IDLE, 20);

    // Reset in the middle of a round at two seconds left
    press_start();
    begin
      int n;
      n = 0;
      while (exp_time_left() != 2 && n < 100) begin
        step();
        n++;
      end
      check("bound_midreset", (n < 100), 1);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (5) step();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.Start_Btn = ~bus.Start_Btn;
      if ($urandom_range(0, 3) == 0) bus.Submit_Btn = ~bus.Submit_Btn;
      bus.Score_Req = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Round controller for the BCD math game. It converts the raw Start/Submit buttons into the single-cycle Game_Start/Load_Input strobes the game ALU consumes, runs the round countdown and drives the ALU's active-low Timeout, requests a fresh random number after every answer, and completes the end-of-game Score_Req handshake. It sits between the board buttons and tick source on one side, and the ALU, RNG and display logic on the other.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per game second; bench uses 10
GAME_SECONDS, 60, round length in seconds; legal range 1..127
SETTLE_CYC, 2, cycles from Load_Input to RNG_Next, covering the ALU PLAY->SCORE->PLAY turnaround

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
Start_Btn  in  1  raw start button level, asynchronous
Submit_Btn  in  1  raw submit button level, asynchronous
Score_Req  in  1  ALU final-score pulse
Game_Start  out  1  1-cycle strobe to ALU
Load_Input  out  1  1-cycle strobe to ALU: answer load, or exit from end-of-game
Timeout  out  1  1 while time remains; 0 once the round has expired
RNG_Next  out  1  1-cycle request for a new number
Time_Left  out  7  seconds remaining, binary
Game_Active  out  1  high in ARM, ROUND, SETTLE
Game_Over  out  1  high in WAIT_SCORE, DONE, ACK

Behaviour:
- Clock and reset: clk, rising edge. reset is synchronous and active-low; reset==0 at a rising edge overrides everything, including mid-round.
- Reset values: Game_Start=0, Load_Input=0, RNG_Next=0, Timeout=1, Time_Left=0, Game_Active=0, Game_Over=0, state=IDLE, tick counter=0, synchroniser flops=0.
- Button inputs: each passes through a 2-flop synchroniser plus a previous-value flop. Edge = sync & ~prev, so an edge is seen 2 cycles after the raw rise. A held button produces exactly one edge.
- IDLE: Timeout=1. On a Start edge -> ARM.
- ARM (1 cycle):
  - Game_Start=1, RNG_Next=1.
  - Time_Left <= GAME_SECONDS, tick counter <= 0.
  - -> ROUND.
- ROUND:
  - The tick counter increments every cycle and wraps at TICKS_PER_SEC-1; on the wrap, Time_Left decrements.
  - When a wrap finds Time_Left==1, Time_Left <= 0 and Timeout <= 0 in the same edge, then -> WAIT_SCORE.
  - On a Submit edge: Load_Input=1 for 1 cycle, -> SETTLE.
- SETTLE:
  - Wait SETTLE_CYC cycles, then RNG_Next=1 for 1 cycle, -> ROUND.
  - Submit edges are ignored (dropped).
  - The timer keeps running. If expiry occurs in SETTLE, the RNG_Next pulse is suppressed and the state goes -> WAIT_SCORE.
- Simultaneous expiry and Submit edge: expiry wins, the Submit is dropped and Load_Input stays 0.
- WAIT_SCORE: Timeout=0. When Score_Req==1 -> DONE. There is no timeout; the block waits indefinitely.
- DONE: Time_Left holds 0. On a Start edge -> ACK.
- ACK (1 cycle): Load_Input=1, Timeout <= 1, -> IDLE.
- Submit edges outside ROUND are discarded. Start edges outside IDLE and DONE are discarded.
- Strobe rules: all strobes are registered and never exceed 1 cycle. Game_Start and Load_Input are never high in the same cycle.
- Unused state encodings -> IDLE with reset output values.

Test Plan:
- Reset then start (TICKS_PER_SEC=10, GAME_SECONDS=3): release reset, raise Start_Btn -> Game_Start and RNG_Next each pulse once, 3 cycles after the raw rise; Time_Left=3; Game_Active=1; Timeout=1.
- Countdown expiry: no Submit -> Time_Left steps 3,2,1,0 every 10 cycles. Timeout falls on the same edge Time_Left reaches 0, 30 cycles after ARM, and the state is WAIT_SCORE.
- Answer submission: Submit held 20 cycles in ROUND -> exactly one Load_Input pulse; RNG_Next pulse exactly 2 cycles later; a second Submit during SETTLE produces no pulse.
- Collision: Submit edge lands on the expiry cycle -> Load_Input=0, Timeout=0, no RNG_Next.
- End handshake: in WAIT_SCORE, pulse Score_Req -> Game_Over=1. A Start press then gives one Load_Input pulse, Timeout returns to 1, and the state is IDLE. A further Start press starts a new game with Time_Left=3.
- Mid-round reset: assert reset=0 for 1 cycle at Time_Left=2 -> all outputs take their reset values on the next edge; no strobe is emitted.
